adder_operand_sequencer: RTL and testbench

//  Drives operand pairs into the nibble adder and checks its results. Sits on the other end
//  of the adder's interface: op_out connects to the adder's ui_in, res_in connects from its uo_out.

---
 rtl/adder_operand_sequencer.sv | 166 ++++++++++++++++
 tb/tb_adder_operand_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/adder_operand_sequencer.sv
// On-chip self-test driver for the nibble adder: issues operand pairs (sweep or LFSR),
// checks each returned sum against the expected value, and reports pass/fail details.
module adder_operand_sequencer #(
  parameter int          LATENCY   = 1,
  parameter int          N_VECTORS = 16,
  parameter logic [7:0]  SEED      = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic [7:0] res_in_i,
  output logic [7:0] op_out_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [7:0] err_count_o,
  output logic [7:0] first_err_ops_o
);

  // state  | meaning
  // IDLE   | waiting for start; op_out held at 0
  // ISSUE  | one operand pair driven per cycle
  // DRAIN  | waiting for the last LATENCY results to return
  // DONE   | one-cycle done pulse, pass updated
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  localparam logic [7:0] SWEEP_LAST = 8'hFF;
  localparam logic [7:0] LFSR_LAST  = 8'(N_VECTORS - 1);
  localparam logic [2:0] DRAIN_INIT = 3'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  drain_q, drain_d;
  logic [7:0]  op_q, op_d;
  logic        mode_q, mode_d;
  logic        run_start;
  logic        issue_d;
  logic [7:0]  err_q, err_d;
  logic [7:0]  first_q, first_d;
  logic        pass_q, pass_d;
  logic        mismatch;

  // Delay line of {valid, op, expected}; stage 0 mirrors op_out
  logic        pv_q   [LATENCY+1];
  logic [7:0]  pop_q  [LATENCY+1];
  logic [7:0]  pexp_q [LATENCY+1];

  // Galois step, left-shifting form of x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    logic [7:0] sh;
    sh = {s[6:0], 1'b0};
    return s[7] ? (sh ^ 8'h71) : sh;
  endfunction

  function automatic logic [7:0] expected_sum(input logic [7:0] op);
    logic [3:0] sum;
    sum = op[7:4] + op[3:0];
    return {4'h0, sum};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'h00;
      drain_q <= 3'd0;
      op_q    <= 8'h00;
      mode_q  <= 1'b0;
      err_q   <= 8'h00;
      first_q <= 8'h00;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    op_d      = 8'h00;
    mode_d    = mode_q;
    run_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_ISSUE;
          mode_d    = mode_i;
          cnt_d     = mode_i ? LFSR_LAST : SWEEP_LAST;
          op_d      = mode_i ? SEED : 8'h00;
          run_start = 1'b1;
        end
      end
      S_ISSUE: begin
        if (cnt_q == 8'h00) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          cnt_d = cnt_q - 8'd1;
          op_d  = mode_q ? lfsr_next(op_q) : op_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (drain_q == 3'd0) state_d = S_DONE;
        else                 drain_d = drain_q - 3'd1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign issue_d  = (state_d == S_ISSUE);
  assign mismatch = pv_q[LATENCY] && (res_in_i != pexp_q[LATENCY]);

  always_comb begin
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;
    if (run_start) begin
      err_d   = 8'h00;
      first_d = 8'h00;
      pass_d  = 1'b0;
    end else begin
      if (mismatch) begin
        if (err_q == 8'h00) first_d = pop_q[LATENCY];
        if (err_q != 8'hFF) err_d = err_q + 8'd1;
      end
      // Final compare lands on the same edge that enters DONE
      if (state_q == S_DRAIN && drain_q == 3'd0) pass_d = (err_d == 8'h00);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= LATENCY; k++) begin
        pv_q[k]   <= 1'b0;
        pop_q[k]  <= 8'h00;
        pexp_q[k] <= 8'h00;
      end
    end else begin
      pv_q[0]   <= issue_d;
      pop_q[0]  <= op_d;
      pexp_q[0] <= expected_sum(op_d);
      for (int k = 1; k <= LATENCY; k++) begin
        pv_q[k]   <= pv_q[k-1];
        pop_q[k]  <= pop_q[k-1];
        pexp_q[k] <= pexp_q[k-1];
      end
    end
  end

  assign op_out_o        = op_q;
  assign busy_o          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done_o          = (state_q == S_DONE);
  assign pass_o          = pass_q;
  assign err_count_o     = err_q;
  assign first_err_ops_o = first_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Bench for adder_operand_sequencer: a behavioural adder with selectable faults answers
// op_out, and a queue of expected pairs plus a reference error tally checks each run.
module tb_adder_operand_sequencer;

  localparam int         LAT   = 1;
  localparam int         N_VEC = 16;
  localparam logic [7:0] SEED  = 8'h01;

  localparam int M_OK    = 0;
  localparam int M_CARRY = 1;
  localparam int M_ZERO  = 2;
  localparam int M_ONES  = 3;
  localparam int M_RAND  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_i = 1'b0;
  logic       mode_i = 1'b0;
  logic [7:0] res_in_i;
  logic [7:0] op_out_o;
  logic       busy_o, done_o, pass_o;
  logic [7:0] err_count_o, first_err_ops_o;

  int         model_sel = M_OK;
  logic [7:0] res_q = 8'h00;
  logic [7:0] rnd_q = 8'h00;
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass = 0;

  adder_operand_sequencer #(.LATENCY(LAT), .N_VECTORS(N_VEC), .SEED(SEED)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .mode_i(mode_i), .res_in_i(res_in_i),
    .op_out_o(op_out_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_count_o(err_count_o), .first_err_ops_o(first_err_ops_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] adder_fn(input int m, input logic [7:0] op);
    logic [4:0] s5;
    s5 = {1'b0, op[7:4]} + {1'b0, op[3:0]};
    case (m)
      M_OK:    return {4'h0, s5[3:0]};
      M_CARRY: return {3'b000, s5};
      M_ZERO:  return 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] ref_lfsr(input logic [7:0] s);
    return s[7] ? ({s[6:0], 1'b0} ^ 8'h71) : {s[6:0], 1'b0};
  endfunction

  // Registered adder: one edge of latency
  always @(posedge clk) begin
    res_q <= adder_fn(model_sel, op_out_o);
    rnd_q <= 8'($urandom);
  end
  assign res_in_i = (model_sel == M_RAND) ? rnd_q : res_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  function automatic logic [26:0] all_outs();
    return {op_out_o, err_count_o, first_err_ops_o, busy_o, done_o, pass_o};
  endfunction

  task automatic run(input logic m, input int model, input int pulse_at);
    int          n, errs, cyc, distinct;
    logic [7:0]  p, op, first;
    logic [255:0] seen_ops;
    bit          got_done;
    n = m ? N_VEC : 256;
    p = SEED;
    errs = 0;
    first = 8'h00;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      op = m ? p : 8'(i);
      exp_q.push_back(op);
      if (adder_fn(model, op) != adder_fn(M_OK, op)) begin
        if (errs == 0) first = op;
        if (errs < 255) errs++;
      end
      p = ref_lfsr(p);
    end
    model_sel = model;
    seen_ops = '0;
    @(negedge clk);
    start_i = 1'b1;
    mode_i  = m;
    @(negedge clk);
    start_i = 1'b0;
    mode_i  = ~m;
    check("busy_after_start", busy_o, 1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      start_i = (i == pulse_at);
      check("op_out", op_out_o, exp_q.pop_front());
      seen_ops[op_out_o] = 1'b1;
    end
    start_i = 1'b0;
    if (m) begin
      distinct = 0;
      for (int k = 1; k < 256; k++) if (seen_ops[k]) distinct++;
      check("lfsr_distinct_nonzero", distinct, n);
    end
    cyc = n - 1;
    got_done = 0;
    for (int k = 0; k < LAT + 8; k++) begin
      @(negedge clk);
      cyc++;
      check("op_idle_after_issue", op_out_o, 0);
      if (done_o) begin
        got_done = 1;
        break;
      end
    end
    check("done_seen", got_done, 1);
    check("done_cycle", cyc, n + LAT);
    check("err_count", err_count_o, errs);
    check("first_err_ops", first_err_ops_o, first);
    check("pass", pass_o, errs == 0);
    @(negedge clk);
    check("done_one_cycle", {done_o, busy_o}, 0);
    check("pass_held", pass_o, errs == 0);
  endtask

  initial begin
    int done_cnt;
    // Reset held with random stimulus
    model_sel = M_RAND;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start_i = 1'($urandom);
      mode_i  = 1'($urandom);
      #1 check("reset_outputs", all_outs(), 0);
    end
    @(negedge clk);
    start_i = 1'b0;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_reset", all_outs(), 0);
    end

    run(1'b0, M_OK, -1);
    run(1'b0, M_CARRY, -1);
    check("carry_err_const", err_count_o, 120);
    check("carry_first_const", first_err_ops_o, 8'h1F);
    run(1'b0, M_ZERO, -1);
    check("zero_err_const", err_count_o, 240);
    run(1'b0, M_ONES, -1);
    check("ones_err_saturated", err_count_o, 8'hFF);
    run(1'b0, M_OK, 50);

    // Abort a run with reset, then confirm no done appears
    model_sel = M_OK;
    @(negedge clk);
    start_i = 1'b1;
    mode_i  = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    repeat (99) @(negedge clk);
    check("busy_before_abort", busy_o, 1);
    reset = 1'b1;
    #1 check("abort_outputs", all_outs(), 0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done_o || busy_o) done_cnt++;
    end
    check("no_done_after_abort", done_cnt, 0);
    run(1'b0, M_OK, -1);

    run(1'b1, M_OK, -1);
    run(1'b1, M_CARRY, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
